// File: rtl/cpuc_reg_bank.sv
// Register bank with per-register source routing, a program counter and a
// run/step/halt controller that faults on out-of-range branch targets.
module cpuc_reg_bank #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_OF_REGS   = 8,
    parameter int unsigned NUM_OF_SRCS   = 16,
    parameter int unsigned NUM_OF_CONSTS = 4,
    parameter int unsigned PROGRAM_SIZE  = 32,
    localparam int unsigned PCW  = $clog2(PROGRAM_SIZE),
    localparam int unsigned SELW = $clog2(NUM_OF_SRCS + NUM_OF_CONSTS)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_OF_SRCS*DATA_WIDTH-1:0]        src_data,
    input  logic [NUM_OF_CONSTS*DATA_WIDTH-1:0]      const_data,
    input  logic [NUM_OF_REGS*SELW-1:0]              reg_sel,
    input  logic [NUM_OF_REGS-1:0]                   reg_wr_en,
    input  logic                                     run,
    input  logic                                     step,
    input  logic                                     halt_req,
    input  logic                                     branch_en,
    input  logic [PCW:0]                             branch_target,
    output logic [(NUM_OF_REGS+1)*DATA_WIDTH-1:0]    reg_outputs,
    output logic [PCW-1:0]                           pc,
    output logic [1:0]                               state,
    output logic                                     exec,
    output logic [31:0]                              cycle_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [PCW-1:0]        pc_q, pc_d;
    logic [31:0]           cycle_cnt_q, cycle_cnt_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_OF_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_OF_REGS];
    logic [DATA_WIDTH-1:0] sel_val [NUM_OF_REGS];
    logic                  fault_c;

    assign exec    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign fault_c = exec && branch_en && (32'(branch_target) >= PROGRAM_SIZE);

    // Per-register source mux; unmatched select codes yield zero.
    always_comb begin
        for (int unsigned r = 0; r < NUM_OF_REGS; r++) begin
            sel_val[r] = '0;
            for (int unsigned s = 0; s < NUM_OF_SRCS; s++) begin
                if (reg_sel[r*SELW +: SELW] == SELW'(s)) begin
                    sel_val[r] = src_data[s*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int unsigned c = 0; c < NUM_OF_CONSTS; c++) begin
                if (reg_sel[r*SELW +: SELW] == SELW'(NUM_OF_SRCS + c)) begin
                    sel_val[r] = const_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Next-state, PC, counter and register update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cycle_cnt_d = cycle_cnt_q;
        for (int unsigned r = 0; r < NUM_OF_REGS; r++) begin
            regs_d[r] = regs_q[r];
        end

        if (exec) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
            if (!fault_c) begin
                for (int unsigned r = 0; r < NUM_OF_REGS; r++) begin
                    if (reg_wr_en[r]) begin
                        regs_d[r] = sel_val[r];
                    end
                end
                if (branch_en) begin
                    pc_d = branch_target[PCW-1:0];
                end else if (pc_q == PCW'(PROGRAM_SIZE - 1)) begin
                    pc_d = '0;
                end else begin
                    pc_d = pc_q + PCW'(1);
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (halt_req) begin
                    state_d = ST_IDLE;
                end else if (run) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fault_c) begin
                    state_d = ST_FAULT;
                end else if (halt_req) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                state_d = fault_c ? ST_FAULT : ST_IDLE;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            cycle_cnt_q <= '0;
            for (int unsigned r = 0; r < NUM_OF_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            for (int unsigned r = 0; r < NUM_OF_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Flat register view with the PC appended as the last entry.
    always_comb begin
        reg_outputs = '0;
        for (int unsigned r = 0; r < NUM_OF_REGS; r++) begin
            reg_outputs[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
        end
        reg_outputs[NUM_OF_REGS*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(pc_q);
    end

    assign pc        = pc_q;
    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpuc_reg_bank.sv
// Self-checking bench for cpuc_reg_bank: directed scenarios plus randomized
// traffic compared against a behavioural model of the register bank.
module tb_cpuc_reg_bank;

    localparam int DW   = 32;
    localparam int NR   = 8;
    localparam int NS   = 16;
    localparam int NC   = 4;
    localparam int PS   = 32;
    localparam int PCW  = 5;
    localparam int SELW = 5;

    logic                    clk;
    logic                    rst_n;
    logic [NS*DW-1:0]        src_data;
    logic [NC*DW-1:0]        const_data;
    logic [NR*SELW-1:0]      reg_sel;
    logic [NR-1:0]           reg_wr_en;
    logic                    run;
    logic                    step;
    logic                    halt_req;
    logic                    branch_en;
    logic [PCW:0]            branch_target;
    logic [(NR+1)*DW-1:0]    reg_outputs;
    logic [PCW-1:0]          pc;
    logic [1:0]              state;
    logic                    exec;
    logic [31:0]             cycle_cnt;

    logic [DW-1:0]   src_a   [NS];
    logic [DW-1:0]   const_a [NC];
    logic [SELW-1:0] sel_a   [NR];

    int n_cmp;
    int n_err;

    // Behavioural model state
    logic [DW-1:0] m_regs [NR];
    int            m_pc;
    logic [31:0]   m_cnt;
    int            m_state;

    cpuc_reg_bank dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_data      (src_data),
        .const_data    (const_data),
        .reg_sel       (reg_sel),
        .reg_wr_en     (reg_wr_en),
        .run           (run),
        .step          (step),
        .halt_req      (halt_req),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .reg_outputs   (reg_outputs),
        .pc            (pc),
        .state         (state),
        .exec          (exec),
        .cycle_cnt     (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        src_data   = '0;
        const_data = '0;
        reg_sel    = '0;
        for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = src_a[i];
        for (int i = 0; i < NC; i++) const_data[i*DW +: DW] = const_a[i];
        for (int i = 0; i < NR; i++) reg_sel[i*SELW +: SELW] = sel_a[i];
    end

    function automatic logic [DW-1:0] rd_reg(input int i);
        return reg_outputs[i*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] pick(input int s);
        if (s < NS) return src_a[s];
        if (s < NS + NC) return const_a[s-NS];
        return '0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_pc    = 0;
        m_cnt   = '0;
        m_state = 0;
    endfunction

    // One rising edge of the machine as described in plain behavioural terms.
    function automatic void model_edge();
        bit ex;
        ex = (m_state == 1) || (m_state == 2);
        if (ex) begin
            m_cnt = m_cnt + 1;
            if (branch_en && int'(branch_target) >= PS) begin
                m_state = 3;
            end else begin
                for (int i = 0; i < NR; i++)
                    if (reg_wr_en[i]) m_regs[i] = pick(int'(sel_a[i]));
                m_pc = branch_en ? int'(branch_target) : (m_pc + 1) % PS;
                if (m_state == 2 || halt_req) m_state = 0;
            end
        end else if (m_state == 0) begin
            if (halt_req)  m_state = 0;
            else if (run)  m_state = 1;
            else if (step) m_state = 2;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        run = 0; step = 0; halt_req = 0; branch_en = 0; branch_target = '0;
        reg_wr_en = '0;
        for (int i = 0; i < NS; i++) src_a[i] = '0;
        for (int i = 0; i < NC; i++) const_a[i] = '0;
        for (int i = 0; i < NR; i++) sel_a[i] = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if (pc !== '0) begin n_err++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        n_cmp++; if (cycle_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt); end
        n_cmp++; if (exec !== 1'b0) begin n_err++; $display("FAIL reset_exec: got %0b expected 0", exec); end
        n_cmp++; if (reg_outputs !== '0) begin n_err++; $display("FAIL reset_regs: got %0h expected 0", reg_outputs); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL idle_no_run: got %0d expected 0", state); end
        run = 1;
        tick();
        n_cmp++; if (state !== 2'd1 || pc !== 5'd0 || cycle_cnt !== 32'd0) begin
            n_err++; $display("FAIL first_run_edge: got state %0d pc %0d cnt %0d expected 1 0 0", state, pc, cycle_cnt);
        end
    endtask

    task automatic test_run_count();
        do_reset();
        run = 1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++; if (pc !== 5'(k)) begin n_err++; $display("FAIL run_pc%0d: got %0d expected %0d", k, pc, k); end
        end
        n_cmp++; if (cycle_cnt !== 32'd3) begin n_err++; $display("FAIL run_cnt: got %0d expected 3", cycle_cnt); end
        n_cmp++; if (reg_outputs[NR*DW-1:0] !== '0) begin n_err++; $display("FAIL run_regs: got %0h expected 0", reg_outputs[NR*DW-1:0]); end
        n_cmp++; if (rd_reg(NR) !== 32'd3) begin n_err++; $display("FAIL run_pc_entry: got %0d expected 3", rd_reg(NR)); end
    endtask

    task automatic test_step_const();
        do_reset();
        const_a[1] = 32'hA5;
        sel_a[2]   = 5'(NS + 1);
        reg_wr_en  = 8'b0000_0100;
        step = 1;
        tick();
        n_cmp++; if (state !== 2'd2 || exec !== 1'b1) begin n_err++; $display("FAIL step_state: got %0d/%0b expected 2/1", state, exec); end
        n_cmp++; if (rd_reg(2) !== 32'd0) begin n_err++; $display("FAIL step_early: got %0h expected 0", rd_reg(2)); end
        step = 0;
        tick();
        n_cmp++; if (rd_reg(2) !== 32'hA5) begin n_err++; $display("FAIL step_reg2: got %0h expected a5", rd_reg(2)); end
        n_cmp++; if (pc !== 5'd1 || state !== 2'd0 || cycle_cnt !== 32'd1) begin
            n_err++; $display("FAIL step_after: got pc %0d state %0d cnt %0d expected 1 0 1", pc, state, cycle_cnt);
        end
        const_a[1] = 32'h5A;
        tick(); tick();
        n_cmp++; if (rd_reg(2) !== 32'hA5 || pc !== 5'd1 || exec !== 1'b0) begin
            n_err++; $display("FAIL step_hold: got reg2 %0h pc %0d exec %0b expected a5 1 0", rd_reg(2), pc, exec);
        end
    endtask

    task automatic test_wrap_branch();
        do_reset();
        run = 1;
        tick();
        for (int k = 0; k < 31; k++) tick();
        n_cmp++; if (pc !== 5'd31) begin n_err++; $display("FAIL wrap_pre: got %0d expected 31", pc); end
        tick();
        n_cmp++; if (pc !== 5'd0) begin n_err++; $display("FAIL wrap_pc: got %0d expected 0", pc); end
        branch_en = 1; branch_target = 6'd7;
        tick();
        n_cmp++; if (pc !== 5'd7 || state !== 2'd1) begin n_err++; $display("FAIL branch_pc: got %0d/%0d expected 7/1", pc, state); end
        n_cmp++; if (cycle_cnt !== 32'd33) begin n_err++; $display("FAIL branch_cnt: got %0d expected 33", cycle_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        run = 1;
        tick();
        halt_req = 1;
        tick();
        n_cmp++; if (state !== 2'd0 || pc !== 5'd1 || cycle_cnt !== 32'd1) begin
            n_err++; $display("FAIL halt_run: got state %0d pc %0d cnt %0d expected 0 1 1", state, pc, cycle_cnt);
        end
        tick();
        n_cmp++; if (state !== 2'd0 || pc !== 5'd1 || exec !== 1'b0) begin
            n_err++; $display("FAIL halt_idle: got state %0d pc %0d exec %0b expected 0 1 0", state, pc, exec);
        end
    endtask

    task automatic test_fault();
        bit ok;
        do_reset();
        run = 1;
        reg_wr_en = '1;
        for (int i = 0; i < NR; i++) begin sel_a[i] = 5'(i); src_a[i] = 32'h1000 + i; end
        tick(); tick();
        n_cmp++; if (rd_reg(3) !== 32'h1003) begin n_err++; $display("FAIL fault_pre: got %0h expected 1003", rd_reg(3)); end
        for (int i = 0; i < NR; i++) src_a[i] = 32'hDEAD_0000 + i;
        branch_en = 1; branch_target = 6'd40;
        tick();
        n_cmp++; if (state !== 2'd3 || pc !== 5'd1 || exec !== 1'b0) begin
            n_err++; $display("FAIL fault_enter: got state %0d pc %0d exec %0b expected 3 1 0", state, pc, exec);
        end
        ok = 1;
        for (int i = 0; i < NR; i++) if (rd_reg(i) !== 32'h1000 + i) ok = 0;
        n_cmp++; if (!ok) begin n_err++; $display("FAIL fault_regs: got %0h expected unchanged", reg_outputs[NR*DW-1:0]); end
        branch_en = 0; step = 1; halt_req = 1;
        for (int k = 0; k < 3; k++) tick();
        n_cmp++; if (state !== 2'd3 || pc !== 5'd1 || rd_reg(0) !== 32'h1000) begin
            n_err++; $display("FAIL fault_stuck: got state %0d pc %0d r0 %0h expected 3 1 1000", state, pc, rd_reg(0));
        end
        do_reset();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL fault_clear: got %0d expected 0", state); end
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1;
        reg_wr_en = '1;
        for (int i = 0; i < NR; i++) begin sel_a[i] = 5'(i); src_a[i] = 32'hC0DE_0000 + i; end
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (state !== 2'd0 || pc !== '0 || cycle_cnt !== 32'd0 || reg_outputs !== '0 || exec !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got state %0d pc %0d cnt %0d regs %0h expected all 0", state, pc, cycle_cnt, reg_outputs);
        end
        #2;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (state !== 2'd1 || reg_outputs !== '0 || cycle_cnt !== 32'd0) begin
            n_err++; $display("FAIL async_resume: got state %0d cnt %0d regs %0h expected 1 0 0", state, cycle_cnt, reg_outputs);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            run       = ($urandom_range(0, 9) < 3);
            step      = ($urandom_range(0, 9) < 2);
            halt_req  = ($urandom_range(0, 19) < 3);
            branch_en = ($urandom_range(0, 4) == 0);
            branch_target = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
            reg_wr_en = 8'($urandom);
            for (int i = 0; i < NS; i++) src_a[i] = $urandom;
            for (int i = 0; i < NC; i++) const_a[i] = $urandom;
            for (int i = 0; i < NR; i++) sel_a[i] = 5'($urandom_range(0, 31));
            @(posedge clk);
            model_edge();
            #1;
            n_cmp++; if (int'(state) != m_state) begin n_err++; $display("FAIL rnd_state c%0d: got %0d expected %0d", c, state, m_state); end
            n_cmp++; if (int'(pc) != m_pc) begin n_err++; $display("FAIL rnd_pc c%0d: got %0d expected %0d", c, pc, m_pc); end
            n_cmp++; if (cycle_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", c, cycle_cnt, m_cnt); end
            n_cmp++; if (exec !== (m_state == 1 || m_state == 2)) begin n_err++; $display("FAIL rnd_exec c%0d: got %0b", c, exec); end
            for (int i = 0; i < NR; i++) begin
                n_cmp++; if (rd_reg(i) !== m_regs[i]) begin
                    n_err++; $display("FAIL rnd_reg%0d c%0d: got %0h expected %0h", i, c, rd_reg(i), m_regs[i]);
                end
            end
            if (m_state == 3 && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_run_count();
        test_step_const();
        test_wrap_branch();
        test_halt();
        test_fault();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
